aes_core_arbiter: RTL

- Shares one aes_cipher_top instance between NUM_REQ independent requesters.
- Round-robin arbitration among requesters; each gets a valid/ready request channel and a valid/ready response channel.
- Sequences the core: pulses ld with the granted key/plaintext, waits for done, captures text_out, returns the ciphertext to the granted requester.
- Sits between the crypto clients and the AES core; one encryption in flight at a time.

---
 rtl/aes_core_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES-128 core between NUM_REQ requesters.
// Round-robin grant, one encryption in flight, ciphertext returned on a
// valid/ready response channel tagged with the requester index.
// Optional feature macro: AES_TIMEOUT_EN (abort WAIT after TIMEOUT cycles,
// respond with resp_err=1 and resp_data=0). Without it WAIT never times out.
module aes_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_text,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   aes_ld,
  output logic [127:0]           aes_key,
  output logic [127:0]           aes_text_in,
  input  logic [127:0]           aes_text_out,
  input  logic                   aes_done
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   text_q, text_d;
  logic [127:0]   data_q, data_d;
  logic           resp_valid_q, resp_valid_d;
  logic           first_q, first_d;

`ifdef AES_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
`endif

  // Catch illegal parameter combinations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) || TIMEOUT < 2) begin : g_param_check
    $error("aes_core_arbiter: illegal parameter combination");
  end

  // Unpack the flat key/text buses into per-requester words.
  logic [127:0] key_arr  [NUM_REQ];
  logic [127:0] text_arr [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign key_arr[gi]  = req_key[128*gi +: 128];
    assign text_arr[gi] = req_text[128*gi +: 128];
  end

  logic           found;
  logic [IDW-1:0] pick;

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    int             cand;
    logic [IDW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      idx  = IDW'(cand);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/LOAD/WAIT/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    resp_id_d    = resp_id_q;
    key_d        = key_q;
    text_d       = text_q;
    data_d       = data_q;
    resp_valid_d = resp_valid_q;
    first_d      = first_q;
    req_ready    = '0;
`ifdef AES_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d         = pick;
          key_d           = key_arr[pick];
          text_d          = text_arr[pick];
          req_ready[pick] = 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        // The first WAIT cycle must ignore a done left over from before ld.
        first_d = 1'b1;
`ifdef AES_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        first_d = 1'b0;
        if (aes_done && !first_q) begin
          data_d       = aes_text_out;
          resp_id_d    = grant_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
`ifdef AES_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d       = '0;
          err_d        = 1'b1;
          resp_id_d    = grant_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
`ifdef AES_TIMEOUT_EN
          err_d        = 1'b0;
`endif
          // Pointer moves past the requester just served, only on completion.
          rr_d         = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      resp_id_q    <= '0;
      key_q        <= '0;
      text_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      first_q      <= 1'b0;
`ifdef AES_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      resp_id_q    <= resp_id_d;
      key_q        <= key_d;
      text_q       <= text_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      first_q      <= first_d;
`ifdef AES_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign aes_ld      = (state_q == LOAD);
  assign aes_key     = key_q;
  assign aes_text_in = text_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = data_q;
`ifdef AES_TIMEOUT_EN
  assign resp_err    = err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule
